// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width bounds for gray_counter and its consumers.
package gray_pkg;

    localparam int GRAY_WIDTH_MIN = 2;
    localparam int GRAY_WIDTH_MAX = 32;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Narrower codes are zero-extended, which leaves the prefix XOR unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_next.sv
// Combinational next-count and wrap/overflow flag for gray_counter.
// GRAY_COUNTER_SAT_EN makes the count hold at its terminal value instead of wrapping.
module gray_next
    import gray_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] bin,
    input  logic             down,
    input  logic             en,
    output logic [WIDTH-1:0] next_bin,
    output logic             wrap
);

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH-1:0] step_bin;
    logic             edge_hit;

    // The extra top bit is the carry (up) or borrow (down); it only feeds the flag.
    assign up_sum   = {1'b0, bin} + {{WIDTH{1'b0}}, 1'b1};
    assign dn_diff  = {1'b0, bin} - {{WIDTH{1'b0}}, 1'b1};
    assign edge_hit = down ? dn_diff[WIDTH] : up_sum[WIDTH];
    assign step_bin = down ? dn_diff[WIDTH-1:0] : up_sum[WIDTH-1:0];

`ifdef GRAY_COUNTER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] stepped,
                                                  input logic             at_edge);
        return at_edge ? cur : stepped;
    endfunction
`endif

    always_comb begin
        next_bin = bin;
        wrap     = 1'b0;
        if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
            next_bin = saturate(bin, step_bin, edge_hit);
`else
            next_bin = step_bin;
`endif
            wrap = edge_hit;
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Parametrised up/down Gray counter with clear, load and registered wrap pulse.
// Define GRAY_COUNTER_SAT_EN for saturating mode (o_wrap then flags an overflow attempt).
module gray_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH     = 2,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_gray,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_wrap
);

    if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
        $error("gray_counter: WIDTH out of range");
    end
    if (64'(RESET_VAL) >= (64'd1 << WIDTH)) begin : g_bad_reset
        $error("gray_counter: RESET_VAL does not fit in WIDTH bits");
    end

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return WIDTH'(bin2gray(32'(b)));
    endfunction

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RESET_VAL)));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] step_bin;
    logic             step_wrap;

    gray_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .bin     (bin_q),
        .down    (i_down),
        .en      (i_en),
        .next_bin(step_bin),
        .wrap    (step_wrap)
    );

    // Gray is encoded from the next binary value, never decoded from bin_q,
    // so o_gray is a clean flop output with exactly one bit moving per step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else if (i_clear) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (i_load) begin
            bin_q  <= i_load_val;
            gray_q <= to_gray(i_load_val);
            wrap_q <= 1'b0;
        end else if (i_en) begin
            bin_q  <= step_bin;
            gray_q <= to_gray(step_bin);
            wrap_q <= step_wrap;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign o_bin  = bin_q;
    assign o_gray = gray_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and random checks of gray_counter at WIDTH 2, 4 (RESET_VAL=5) and 8.
module tb_gray_counter;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=2 instance
    logic       rst_a, clear_a, load_a, en_a, down_a;
    logic [1:0] load_val_a, gray_a, bin_a;
    logic       wrap_a;
    // WIDTH=4, RESET_VAL=5 instance
    logic       rst_b, clear_b, load_b, en_b, down_b;
    logic [3:0] load_val_b, gray_b, bin_b;
    logic       wrap_b;
    // WIDTH=8 instance
    logic       rst_c, clear_c, load_c, en_c, down_c;
    logic [7:0] load_val_c, gray_c, bin_c;
    logic       wrap_c;

    gray_counter #(.WIDTH(2), .RESET_VAL(0)) u_a (
        .i_clk(clk), .i_rst(rst_a), .i_clear(clear_a), .i_load(load_a),
        .i_load_val(load_val_a), .i_en(en_a), .i_down(down_a),
        .o_gray(gray_a), .o_bin(bin_a), .o_wrap(wrap_a)
    );

    gray_counter #(.WIDTH(4), .RESET_VAL(5)) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_clear(clear_b), .i_load(load_b),
        .i_load_val(load_val_b), .i_en(en_b), .i_down(down_b),
        .o_gray(gray_b), .o_bin(bin_b), .o_wrap(wrap_b)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(0)) u_c (
        .i_clk(clk), .i_rst(rst_c), .i_clear(clear_c), .i_load(load_c),
        .i_load_val(load_val_c), .i_en(en_c), .i_down(down_c),
        .o_gray(gray_c), .o_bin(bin_c), .o_wrap(wrap_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] up_gray [4];
    logic       up_wrap [4];
    logic [1:0] dn_gray [4];
    logic       dn_wrap [4];
    logic [7:0] mb, prev_gray;
    logic       mw, moved;

    initial begin
`ifdef GRAY_COUNTER_SAT_EN
        up_gray = '{2'b01, 2'b11, 2'b10, 2'b10};
        up_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
        dn_gray = '{2'b00, 2'b00, 2'b00, 2'b00};
        dn_wrap = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        up_gray = '{2'b01, 2'b11, 2'b10, 2'b00};
        up_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
        dn_gray = '{2'b10, 2'b11, 2'b01, 2'b00};
        dn_wrap = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
        {rst_a, rst_b, rst_c} = 3'b111;
        {clear_a, load_a, en_a, down_a} = '0;
        {clear_b, load_b, en_b, down_b} = '0;
        {clear_c, load_c, en_c, down_c} = '0;
        load_val_a = '0;
        load_val_b = '0;
        load_val_c = '0;
        #12;
        check("rst_a_gray", 32'(gray_a), 32'h0);
        check("rst_a_wrap", 32'(wrap_a), 32'h0);
        check("rst_b_bin",  32'(bin_b),  32'h5);
        check("rst_b_gray", 32'(gray_b), 32'h7);
        check("rst_c_bin",  32'(bin_c),  32'h0);
        step();
        {rst_a, rst_b, rst_c} = 3'b000;

        // WIDTH=2 count up through the wrap
        en_a = 1'b1;
        down_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("up_gray%0d", i), 32'(gray_a), 32'(up_gray[i]));
            check($sformatf("up_wrap%0d", i), 32'(wrap_a), 32'(up_wrap[i]));
        end
        en_a = 1'b0;
        step();
        check("idle_wrap", 32'(wrap_a), 32'h0);
        check("idle_gray", 32'(gray_a), 32'(up_gray[3]));

        // WIDTH=2 count down from reset
        rst_a = 1'b1;
        #1;
        rst_a = 1'b0;
        en_a = 1'b1;
        down_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("dn_gray%0d", i), 32'(gray_a), 32'(dn_gray[i]));
            check($sformatf("dn_wrap%0d", i), 32'(wrap_a), 32'(dn_wrap[i]));
        end
        en_a = 1'b0;

        // WIDTH=4 load beats enable, then one up step
        load_b = 1'b1;
        load_val_b = 4'd9;
        en_b = 1'b1;
        step();
        check("load_bin",  32'(bin_b),  32'd9);
        check("load_gray", 32'(gray_b), 32'b1101);
        check("load_wrap", 32'(wrap_b), 32'h0);
        load_b = 1'b0;
        step();
        check("ld_up_bin",  32'(bin_b),  32'd10);
        check("ld_up_gray", 32'(gray_b), 32'b1111);

        // clear beats load and enable
        clear_b = 1'b1;
        load_b = 1'b1;
        load_val_b = 4'd7;
        step();
        check("clr_bin",  32'(bin_b),  32'h0);
        check("clr_gray", 32'(gray_b), 32'h0);
        check("clr_wrap", 32'(wrap_b), 32'h0);
        clear_b = 1'b0;

        // loading the terminal value never flags a wrap; stepping past it does
        load_val_b = 4'd15;
        step();
        check("ld15_wrap", 32'(wrap_b), 32'h0);
        check("ld15_gray", 32'(gray_b), 32'b1000);
        load_b = 1'b0;
        step();
        check("w15_wrap", 32'(wrap_b), 32'h1);
`ifdef GRAY_COUNTER_SAT_EN
        check("w15_bin", 32'(bin_b), 32'd15);
`else
        check("w15_bin", 32'(bin_b), 32'd0);
`endif
        en_b = 1'b0;

        // asynchronous reset between edges
        #3;
        rst_b = 1'b1;
        #1;
        check("arst_bin",  32'(bin_b),  32'd5);
        check("arst_gray", 32'(gray_b), 32'b0111);
        check("arst_wrap", 32'(wrap_b), 32'h0);
        rst_b = 1'b0;

        // WIDTH=8 terminal step
        load_c = 1'b1;
        load_val_c = 8'd255;
        step();
        load_c = 1'b0;
        en_c = 1'b1;
        down_c = 1'b0;
        step();
        check("t255_wrap", 32'(wrap_c), 32'h1);
`ifdef GRAY_COUNTER_SAT_EN
        check("t255_bin", 32'(bin_c), 32'd255);
`else
        check("t255_bin", 32'(bin_c), 32'd0);
`endif

        // WIDTH=8 random walk against a behavioural model
        mb = bin_c;
        for (int n = 0; n < 10000; n++) begin
            en_c = 1'($urandom_range(0, 1));
            down_c = 1'($urandom_range(0, 1));
            prev_gray = gray_c;
            mw = 1'b0;
            moved = 1'b0;
            if (en_c) begin
                if (!down_c) begin
                    if (mb == 8'd255) begin
                        mw = 1'b1;
`ifndef GRAY_COUNTER_SAT_EN
                        mb = 8'd0;
                        moved = 1'b1;
`endif
                    end else begin
                        mb = mb + 8'd1;
                        moved = 1'b1;
                    end
                end else begin
                    if (mb == 8'd0) begin
                        mw = 1'b1;
`ifndef GRAY_COUNTER_SAT_EN
                        mb = 8'd255;
                        moved = 1'b1;
`endif
                    end else begin
                        mb = mb - 8'd1;
                        moved = 1'b1;
                    end
                end
            end
            step();
            check("rnd_bin",  32'(bin_c),  32'(mb));
            check("rnd_gray", 32'(gray_c), 32'(mb ^ (mb >> 1)));
            check("rnd_wrap", 32'(wrap_c), 32'(mw));
            check("rnd_dec",  gray2bin(32'(gray_c)), 32'(bin_c));
            if (moved) begin
                check("rnd_1bit", 32'($countones(prev_gray ^ gray_c)), 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
